// File: rtl/kanagawa_dcfifo_read_adapter.sv
// kanagawa_dcfifo_read_adapter
// Read-side stage behind a show-ahead dual-clock FIFO, clocked in the FIFO
// read domain. It turns the FIFO empty/rdreq/q interface into a registered
// valid/ready stream through a 2-entry elastic buffer. fifo_rdreq depends only
// on registered state, flush and fifo_empty, so out_ready never reaches the
// FIFO read path combinationally.
//
// Ports
//   clk         read-domain clock (FIFO rdclk)
//   rst_n       asynchronous active-low reset
//   fifo_empty  show-ahead FIFO empty flag
//   fifo_q      show-ahead FIFO head data, valid while fifo_empty=0
//   fifo_rdreq  pop request to the FIFO
//   flush       synchronous discard of buffered entries
//   out_valid   stream valid (registered)
//   out_ready   stream ready
//   out_data    stream data (registered)
//   occupancy   entries held: 0, 1 or 2 (registered)
//   xfer_count  completed output handshakes, wraps (registered)
module kanagawa_dcfifo_read_adapter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_q,
    output logic                 fifo_rdreq,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [1:0]           occ_q, occ_d;

    logic pop;
    logic drain;

    // Pop decision uses only registered state, flush and the FIFO flag.
    assign pop   = rst_n & ~fifo_empty & ~flush & (state_q != S_TWO);
    assign drain = valid_q & out_ready;

    // Next-state, buffer and status computation.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q + CNT_WIDTH'(drain);
        valid_d = 1'b0;
        occ_d   = 2'd0;

        if (flush) begin
            // Buffered contents become don't-care; keep head to avoid toggling.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (pop) begin
                        state_d = S_ONE;
                        head_d  = fifo_q;
                    end
                end
                S_ONE: begin
                    if (pop && drain) begin
                        head_d = fifo_q;
                    end else if (pop) begin
                        state_d = S_TWO;
                        tail_d  = fifo_q;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        state_d = S_ONE;
                        head_d  = tail_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end

        case (state_d)
            S_ONE: begin
                valid_d = 1'b1;
                occ_d   = 2'd1;
            end
            S_TWO: begin
                valid_d = 1'b1;
                occ_d   = 2'd2;
            end
            default: begin
                valid_d = 1'b0;
                occ_d   = 2'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign fifo_rdreq = pop;
    assign out_valid  = valid_q;
    assign out_data   = head_q;
    assign occupancy  = occ_q;
    assign xfer_count = cnt_q;

    // Simulation checks of the interface contract.
    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_rdreq |-> !fifo_empty);

    a_head_stable: assert property (
        @(posedge clk) disable iff (!rst_n) (valid_q && !out_ready) |=> $stable(head_q));

    a_occ_range: assert property (
        @(posedge clk) disable iff (!rst_n) occ_q <= 2'd2);

endmodule

// File: tb/tb_kanagawa_dcfifo_read_adapter.sv
// Bench for kanagawa_dcfifo_read_adapter: a queue-based show-ahead FIFO model
// feeds the DUT, pops are pushed to a scoreboard, and a negedge monitor checks
// every handshake, occupancy, valid, pop request and transfer count.
module tb_kanagawa_dcfifo_read_adapter;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_WIDTH = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_q;
    logic                 fifo_rdreq;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           occupancy;
    logic [CNT_WIDTH-1:0] xfer_count;

    kanagawa_dcfifo_read_adapter #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rdreq (fifo_rdreq),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] src_q [$];   // FIFO contents
    logic [WIDTH-1:0] exp_q [$];   // entries expected in the adapter, in order
    logic             hide = 1'b0; // forces fifo_empty while data is present
    logic             pop_pend = 1'b0;
    logic [CNT_WIDTH-1:0] exp_cnt = '0;
    int               total_drains = 0;

    function automatic void check(input string name, input logic [WIDTH-1:0] act,
                                  input logic [WIDTH-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic update_fifo();
        fifo_empty = hide || (src_q.size() == 0);
        fifo_q     = (src_q.size() != 0) ? src_q[0] : 32'hDEAD_BEEF;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pend) void'(src_q.pop_front());
        pop_pend = 1'b0;
        update_fifo();
    endtask

    // Monitor: outputs and inputs are both stable at the falling edge.
    always @(negedge clk) begin
        logic exp_rd;
        logic [WIDTH-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = '0;
            check("rst_out_data", out_data, '0);
        end
        check("occupancy", WIDTH'(occupancy), WIDTH'(exp_q.size()));
        check("out_valid", WIDTH'(out_valid), WIDTH'(exp_q.size() != 0));
        check("xfer_count", WIDTH'(xfer_count), WIDTH'(exp_cnt));
        exp_rd = rst_n && !fifo_empty && !flush && (exp_q.size() != 2);
        check("fifo_rdreq", WIDTH'(fifo_rdreq), WIDTH'(exp_rd));
        if (fifo_rdreq && fifo_empty) check("rdreq_while_empty", 32'd1, 32'd0);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("drain_without_entry", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
            end
            exp_cnt = exp_cnt + 1'b1;
            total_drains++;
        end
        if (rst_n && flush) exp_q.delete();
        if (rst_n && fifo_rdreq) begin
            exp_q.push_back(fifo_q);
            pop_pend = 1'b1;
        end
    end

    task automatic wait_occ(input logic [1:0] target, input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            if (occupancy == target) break;
            tick();
        end
        if (k == 20) check({name, "_timeout"}, WIDTH'(occupancy), WIDTH'(target));
    endtask

    task automatic drain_all(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !pop_pend) break;
            tick();
        end
        if (k == budget) check({name, "_timeout"}, WIDTH'(exp_q.size() + src_q.size()), '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_q.delete();
        update_fifo();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        update_fifo();

        // 1: three entries with the sink always ready
        do_reset();
        check("t1_reset_cnt", WIDTH'(xfer_count), 32'd0);
        out_ready = 1'b1;
        src_q.push_back(32'hA);
        src_q.push_back(32'hB);
        src_q.push_back(32'hC);
        update_fifo();
        repeat (6) tick();
        check("t1_xfer_count", WIDTH'(xfer_count), 32'd3);
        check("t1_occupancy", WIDTH'(occupancy), 32'd0);

        // 2: stall with five entries available
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) src_q.push_back(32'h100 + 32'(i));
        update_fifo();
        repeat (10) tick();
        check("t2_occupancy", WIDTH'(occupancy), 32'd2);
        check("t2_head", out_data, 32'h100);
        check("t2_remaining", WIDTH'(src_q.size()), 32'd3);
        out_ready = 1'b1;
        drain_all(50, "t2_drain");
        check("t2_xfer_count", WIDTH'(xfer_count), 32'd8);

        // 4: flush with both entries held
        out_ready = 1'b0;
        src_q.push_back(32'h21);
        src_q.push_back(32'h22);
        update_fifo();
        wait_occ(2'd2, "t4_fill");
        flush = 1'b1;
        src_q.push_back(32'h99);
        update_fifo();
        #1 check("t4_no_pop_flush", WIDTH'(fifo_rdreq), 32'd0);
        tick();
        flush = 1'b0;
        check("t4_valid", WIDTH'(out_valid), 32'd0);
        check("t4_occupancy", WIDTH'(occupancy), 32'd0);
        src_q.delete();
        src_q.push_back(32'h55);
        update_fifo();
        tick();
        tick();
        check("t4_next_data", out_data, 32'h55);
        out_ready = 1'b1;
        drain_all(20, "t4_drain");

        // 5: counter wrap at four bits
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) src_q.push_back(32'h500 + 32'(i));
        update_fifo();
        drain_all(60, "t5_drain");
        check("t5_wrap", WIDTH'(xfer_count), 32'd1);

        // 3: random FIFO availability and sink backpressure
        total_drains = 0;
        for (int i = 0; i < 1000; i++) src_q.push_back(32'hC000_0000 + 32'(i));
        begin
            int k;
            for (k = 0; k < 20000; k++) begin
                if (src_q.size() == 0 && exp_q.size() == 0 && !pop_pend) break;
                tick();
                hide      = ($urandom_range(0, 9) < 3);
                out_ready = ($urandom_range(0, 9) < 6);
                update_fifo();
            end
            if (k == 20000) check("t3_timeout", WIDTH'(exp_q.size()), '0);
        end
        hide = 1'b0;
        update_fifo();
        check("t3_total", WIDTH'(total_drains), 32'd1000);

        // 6: asynchronous reset while two entries are held
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) src_q.push_back(32'h600 + 32'(i));
        update_fifo();
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        wait_occ(2'd2, "t6_fill");
        #1 rst_n = 1'b0;
        #1;
        check("t6_valid", WIDTH'(out_valid), 32'd0);
        check("t6_occupancy", WIDTH'(occupancy), 32'd0);
        check("t6_xfer_count", WIDTH'(xfer_count), 32'd0);
        check("t6_rdreq", WIDTH'(fifo_rdreq), 32'd0);
        src_q.delete();
        update_fifo();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        src_q.push_back(32'h77);
        update_fifo();
        drain_all(20, "t6_after");
        check("t6_after_cnt", WIDTH'(xfer_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
